instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the byte-addressed, little-endian, combinational instruction memory (64-bit byte address in, 32-bit instruction out).
- Owns the 64-bit PC and drives the memory address.
- Captures the returned instruction together with its PC into a small FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts branch redirects from execute, which flush the FIFO.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
DEPTH, 2, fetch FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
fetch_en  input  1  1 = fetching permitted; 0 = hold PC, no enqueue.
imem_adr  output  64  byte address to instruction memory; equals pc_q.
imem_instr  input  32  instruction returned combinationally for imem_adr in the same cycle.
redirect_valid  input  1  branch/jump taken; overrides everything else.
redirect_target  input  64  new PC; bits [1:0] ignored (forced 0).
out_valid  output  1  FIFO head valid for decode.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  32  head instruction.
out_pc  output  64  PC of the head instruction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_q = RESET_PC; FIFO count = 0; read/write pointers = 0; storage cleared to 0.
  - Outputs: out_valid = 0, out_instr = 0, out_pc = 0, imem_adr = RESET_PC.
- Definitions:
  - deq = out_valid & out_ready.
  - out_valid = (count != 0) & ~redirect_valid. No transfer occurs in a redirect cycle.
  - can_fetch = fetch_en & ~redirect_valid & ((count < DEPTH) | deq).
- Fetch cycle (can_fetch = 1):
  - Enqueue {pc_q, imem_instr} at the write pointer.
  - pc_q <= pc_q + 4; the addition wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC -> 0).
- Dequeue: advances the read pointer; out_instr/out_pc always reflect the head entry. There is no empty-bypass, so minimum latency from PC present to out_valid is 1 cycle.
- Count update: +1 on fetch only, -1 on deq only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Full (count == DEPTH) with deq in the same cycle: fetch still occurs and count stays at DEPTH.
- Empty with fetch: out_valid rises the next cycle.
- Redirect (redirect_valid = 1):
  - count <= 0 and pointers reset; no enqueue and no dequeue that cycle.
  - pc_q <= {redirect_target[63:2], 2'b00}.
  - fetch_en is irrelevant in that cycle; the next fetch, if fetch_en = 1, uses the target on the following cycle.
  - Back-to-back redirects: the last one wins.
- fetch_en low:
  - pc_q holds, nothing is enqueued, and the FIFO continues draining to decode.
- Reset asserted mid-stream: FIFO contents are discarded immediately, with no partial handshake.
- Throughput: 1 instruction/cycle sustained while out_ready = 1.
- Decode must not see any entry fetched before a redirect.

Decomposition:
- Package cpu_fetch_pkg:
  - ADDR_W = 64, INSTR_W = 32, INSTR_BYTES = 4.
  - Struct fetch_entry_t {pc[63:0], instr[31:0]}.
  - Function next_pc(pc) = pc + INSTR_BYTES.
- Sub-module fetch_queue:
  - Parameterized DEPTH FIFO of fetch_entry_t with push/pop/flush and full/empty/count.
  - Synchronous flush, asynchronous active-low reset.
- The top level holds the PC register, the can_fetch logic and the redirect muxing.

Test Plan:
- Reset release, memory model returns 32'h8B1F03E5 @0, 32'hF84000A4 @4, 32'h8B040086 @8, out_ready = 1 -> out_valid first high 1 cycle after release with out_pc = 0, instr 8B1F03E5; then pc 4 and pc 8 on consecutive cycles.
- out_ready = 0 for 5 cycles after reset -> count saturates at 2 entries (pc 0, pc 4), imem_adr holds at 8; out_ready raised -> pc 0, 4, 8 delivered in order with no gap or duplicate.
- FIFO full plus deq in the same cycle -> entry pc 8 enqueued, count remains 2, imem_adr advances to 12.
- Redirect to 0x0000_0000_0000_0043 while FIFO holds 2 entries -> out_valid 0 that cycle and the next; then out_pc = 0x40; stale pc 4/8 entries never appear.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC, out_ready = 1 -> out_pc sequence FFFF_FFFF_FFFF_FFFC, then 0, then 4.
- fetch_en low for 3 cycles with out_ready = 1 -> FIFO drains to empty, imem_adr constant, out_valid 0; fetch_en high -> resumes at the held PC, no skipped address. Also assert rst_n low mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: entry layout and the sequential PC step.
package cpu_fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Wraps modulo 2^64 through the natural truncation of the sum.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Power-of-two FIFO of fetch entries with push/pop, synchronous flush and occupancy count.
module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer/count next state; flush wins over any simultaneous push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures {pc, instr} from the combinational imem into a FIFO,
// hands entries to decode via valid/ready, and flushes on execute redirects.
module instruction_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  output logic [ADDR_W-1:0]   imem_adr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc
);

  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic                    deq_s;
  logic                    can_fetch_s;
  logic                    full_s;
  logic [$clog2(DEPTH):0]  count_s;
  fetch_entry_t            head_s;
  fetch_entry_t            push_entry_s;

  // A redirect cycle suppresses both transfer directions so no stale entry escapes.
  assign out_valid    = (count_s != '0) && !redirect_valid;
  assign deq_s        = out_valid && out_ready;
  assign can_fetch_s  = fetch_en && !redirect_valid && (!full_s || deq_s);
  assign push_entry_s = '{pc: pc_q, instr: imem_instr};

  // PC next state: redirect beats sequential advance, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (can_fetch_s) begin
      pc_d = next_pc(pc_q);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (can_fetch_s),
    .push_data_i (push_entry_s),
    .pop_i       (deq_s),
    .flush_i     (redirect_valid),
    .head_o      (head_s),
    .full_o      (full_s),
    .count_o     (count_s)
  );

  assign imem_adr  = pc_q;
  assign out_instr = head_s.instr;
  assign out_pc    = head_s.pc;

endmodule
